// File: rtl/mem_pkg.sv
// Shared definitions for the memory master: default geometry, command opcodes
// and FSM state encoding.
package mem_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 11;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address generator: loads start/length, steps the address per beat and
// flags the final beat and any range that would run past the last valid word.
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] len,
  input  logic          single,
  input  logic          inc,
  output logic [AW-1:0] cur,
  output logic          last,
  output logic          rng_err
);

  localparam logic [AW:0] MAX_ADDR = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] span;
  logic [AW:0]   end_addr;

  // Range check is evaluated on the raw command so the FSM can branch at acceptance.
  always_comb begin
    span     = (single || len == '0) ? '0 : len - AW'(1);
    end_addr = {1'b0, start} + {1'b0, span};
    rng_err  = ({1'b0, start} > MAX_ADDR) || (end_addr > MAX_ADDR);
    cur_d    = cur_q;
    rem_d    = rem_q;
    if (load) begin
      cur_d = start;
      rem_d = span;
    end else if (inc) begin
      cur_d = cur_q + AW'(1);
      rem_d = rem_q - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      rem_q <= '0;
    end else begin
      cur_q <= cur_d;
      rem_q <= rem_d;
    end
  end

  assign cur  = cur_q;
  assign last = (rem_q == '0);

endmodule

// File: rtl/mem_master.sv
// Command-driven memory master: single writes, range fills and range reads
// against a one-cycle-latency memory, with one response stream back.
module mem_master
  import mem_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_err_q, rsp_err_d;

  logic          ag_load, ag_inc, ag_last, ag_rng_err;
  logic [AW-1:0] ag_cur;

  mem_addr_gen #(.AW(AW), .DEPTH(DEPTH)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ag_load),
    .start   (cmd_addr),
    .len     (cmd_len),
    .single  (op_e'(cmd_op) == OP_WRITE),
    .inc     (ag_inc),
    .cur     (ag_cur),
    .last    (ag_last),
    .rng_err (ag_rng_err)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    ag_load    = 1'b0;
    ag_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          data_d     = cmd_data;
          ag_load    = 1'b1;
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b0;
          if (op_e'(cmd_op) == OP_NOP) begin
            state_d = S_RESP;
          end else if (ag_rng_err) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else if (op_e'(cmd_op) == OP_READ) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (ag_last) state_d = S_RESP;
        else         ag_inc  = 1'b1;
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        rsp_data_d = mem_dout;
        rsp_last_d = ag_last;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        // Non-final read beats loop back for the next word; everything else ends here.
        if (rsp_ready) begin
          if (op_q == OP_READ && !rsp_last_q) begin
            ag_inc  = 1'b1;
            state_d = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    data_q <= data_d;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign mem_wr    = (state_q == S_WR);
  assign mem_rd    = (state_q == S_RD);
  assign mem_addr  = (state_q == S_WR || state_q == S_RD) ? ag_cur : '0;
  assign mem_din   = (state_q == S_WR) ? data_q : '0;

endmodule
